// File: rtl/bsg_adder_wide_seq_pkg.sv
// rtl/bsg_adder_wide_seq_pkg.sv - shared types and helpers for the sequential wide adder
package bsg_adder_wide_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chunk counter width: never narrower than one bit, even for a single chunk.
  function automatic int chunk_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_adder_ripple_carry.sv
// rtl/bsg_adder_ripple_carry.sv - combinational ripple-carry adder slice
module bsg_adder_ripple_carry #(
  parameter int width_p = 17
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] s_o,
  output logic               c_o
);

  assign {c_o, s_o} = a_i + b_i;

endmodule

// File: rtl/bsg_adder_wide_seq.sv
// rtl/bsg_adder_wide_seq.sv - multi-cycle wide add/subtract using one narrow slice
module bsg_adder_wide_seq
  import bsg_adder_wide_seq_pkg::*;
#(
  parameter int width_p       = 64,
  parameter int slice_width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               sub_i,
  output logic               v_o,
  output logic [width_p-1:0] s_o,
  output logic               c_o,
  input  logic               yumi_i
);

  localparam int n_lp     = (slice_width_p > 0) ? (width_p / slice_width_p) : 1;
  localparam int cnt_w_lp = chunk_cnt_width(n_lp);

  typedef logic [cnt_w_lp-1:0] chunk_cnt_t;

  localparam chunk_cnt_t last_chunk_lp = chunk_cnt_t'(n_lp - 1);

  if ((slice_width_p < 1) ? 1'b1 : ((width_p % slice_width_p) != 0)) begin : g_bad_params
    $error("bsg_adder_wide_seq: width_p must be a positive multiple of slice_width_p");
  end

  state_e                   state_r, state_n;
  logic [width_p-1:0]       a_r, b_r, s_r;
  logic                     c_r;
  chunk_cnt_t               cnt_r;
  logic [slice_width_p:0]   slice_sum;
  logic                     slice_c;
  logic [slice_width_p-1:0] chunk_sum;
  logic [width_p-1:0]       s_next;
  logic                     accept;

  // The low guard bit {1,carry} turns the stored carry into the slice carry-in.
  bsg_adder_ripple_carry #(.width_p(slice_width_p + 1)) u_slice (
    .a_i({a_r[slice_width_p-1:0], 1'b1}),
    .b_i({b_r[slice_width_p-1:0], c_r}),
    .s_o(slice_sum),
    .c_o(slice_c)
  );

  assign chunk_sum = slice_sum[slice_width_p:1];

  if (n_lp == 1) begin : g_single
    assign s_next = chunk_sum;
  end else begin : g_multi
    assign s_next = {chunk_sum, s_r[width_p-1:slice_width_p]};
  end

  assign accept = v_i & ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (v_i) state_n = BUSY;
      BUSY:    if (cnt_r == last_chunk_lp) state_n = DONE;
      DONE:    if (yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_r == IDLE);
    v_o     = (state_r == DONE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      c_r   <= 1'b0;
      cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: if (accept) begin
          a_r   <= a_i;
          b_r   <= sub_i ? ~b_i : b_i;
          c_r   <= sub_i;
          cnt_r <= '0;
        end
        BUSY: begin
          a_r   <= a_r >> slice_width_p;
          b_r   <= b_r >> slice_width_p;
          s_r   <= s_next;
          c_r   <= slice_c;
          cnt_r <= cnt_r + chunk_cnt_t'(1);
        end
        default: ;
      endcase
    end
  end

  assign s_o = s_r;
  assign c_o = c_r;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule
